// File: rtl/mcu_reg_spi_if.sv
// SPI pin bundle between the board MCU (master) and the FPGA register port (slave).
// Signalling: no valid/ready; cs_n low frames a transfer, mosi sampled on sclk rise, miso changes on sclk fall.
interface mcu_reg_spi_if;
    logic spi_sclk;
    logic spi_cs_n;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (
        output spi_sclk,
        output spi_cs_n,
        output spi_mosi,
        input  spi_miso,
        input  spi_miso_oe
    );

    modport slave (
        input  spi_sclk,
        input  spi_cs_n,
        input  spi_mosi,
        output spi_miso,
        output spi_miso_oe
    );
endinterface

// File: rtl/mcu_reg_spi.sv
// Mode-0 SPI slave that turns MCU frames into 12-bit register writes (with a toggle strobe)
// and returns a 32-bit status snapshot or ID word on reads. Pins are oversampled in the clk domain.
module mcu_reg_spi #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] ID_WORD     = 32'hFCA7_0001
) (
    input  logic              clk,
    input  logic              cpu_reset,
    mcu_reg_spi_if.slave      spi,
    input  logic [31:0]       status_reg,
    output logic [11:0]       wr_reg,
    output logic [3:0]        wr_reg_addr,
    output logic              wr_reg_changed,
    output logic [2:0]        state_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        WDATA = 3'd2,
        RDATA = 3'd3,
        DROP  = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_last_q, cs_last_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   rise, fall, cs_rise, cs_fall;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [15:0] sh_q;
    logic [15:0] sh_next;
    logic [3:0]  addr_q;
    logic [31:0] rd_sh_q;
    logic        miso_q, oe_q;
    logic [11:0] wr_reg_q;
    logic [3:0]  wr_addr_q;
    logic        tog_q;

    // cs_n chain resets to 0 ("selected") so a frame already in progress when reset
    // drops cannot look like a fresh falling edge; a real high must be seen first.
    always_ff @(posedge clk or posedge cpu_reset) begin
        if (cpu_reset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_last_q <= 1'b0;
            cs_last_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.spi_sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi.spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.spi_mosi};
            sclk_last_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_last_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s    = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
    assign rise    = sclk_s & ~sclk_last_q;
    assign fall    = ~sclk_s & sclk_last_q;
    assign cs_rise = cs_s & ~cs_last_q;
    assign cs_fall = ~cs_s & cs_last_q;
    assign sh_next = {sh_q[14:0], mosi_s};

    // cs_n edges are tested first so a coincident sclk rise is dropped.
    always_ff @(posedge clk or posedge cpu_reset) begin
        if (cpu_reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            addr_q    <= '0;
            rd_sh_q   <= '0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            wr_reg_q  <= '0;
            wr_addr_q <= '0;
            tog_q     <= 1'b0;
        end else if (cs_rise) begin
            state_q <= IDLE;
            miso_q  <= 1'b0;
            oe_q    <= 1'b0;
        end else if (state_q == IDLE) begin
            if (cs_fall) begin
                state_q <= CMD;
                cnt_q   <= '0;
                miso_q  <= 1'b0;
                oe_q    <= 1'b1;
            end
        end else if (rise) begin
            cnt_q <= (cnt_q == 6'd40) ? 6'd40 : cnt_q + 6'd1;
            sh_q  <= sh_next;
            case (state_q)
                CMD: if (cnt_q == 6'd7) begin
                    addr_q <= sh_next[3:0];
                    if (sh_next[7]) begin
                        state_q <= WDATA;
                    end else begin
                        state_q <= RDATA;
                        rd_sh_q <= (sh_next[3:0] == 4'hF) ? ID_WORD : status_reg;
                    end
                end
                WDATA: if (cnt_q == 6'd23) begin
                    wr_reg_q  <= sh_next[11:0];
                    wr_addr_q <= addr_q;
                    tog_q     <= ~tog_q;
                    state_q   <= DROP;
                end
                RDATA: if (cnt_q == 6'd39) begin
                    state_q <= DROP;
                    miso_q  <= 1'b0;
                end
                default: ;
            endcase
        end else if (fall && state_q == RDATA) begin
            // Shifting zeros in makes MISO hold 0 once all 32 bits are out.
            miso_q  <= rd_sh_q[31];
            rd_sh_q <= {rd_sh_q[30:0], 1'b0};
        end
    end

    assign spi.spi_miso    = miso_q;
    assign spi.spi_miso_oe = oe_q;
    assign wr_reg          = wr_reg_q;
    assign wr_reg_addr     = wr_addr_q;
    assign wr_reg_changed  = tog_q;
    assign state_o         = state_q;

endmodule
